// File: rtl/bcd_counter.sv
// bcd_counter: prescaled multi-digit BCD up/down counter with load, step and wrap pulses
module bcd_counter #(
  parameter int DIGITS = 4,
  parameter int DIV    = 50_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                up,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic                step,
  output logic                wrap
);
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  logic [PW-1:0]       pre_q, pre_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d, ld_san;
  logic                step_q, wrap_q, tick, roll;
  logic [3:0]          d;
  assign tick = en && (pre_q == PW'(DIV - 1));
  assign pre_d = !en ? pre_q : tick ? '0 : pre_q + PW'(1);
  // roll carries the ripple condition; when it survives all digits the count wrapped
  always_comb begin
    bcd_d = bcd_q;
    ld_san = '0;
    roll = 1'b1;
    d = '0;
    for (int i = 0; i < DIGITS; i++) begin
      d = bcd_q[4*i +: 4];
      bcd_d[4*i +: 4] = !roll ? d : up ? (d == 4'd9 ? 4'd0 : d + 4'd1) : (d == 4'd0 ? 4'd9 : d - 4'd1);
      roll = roll && (d == (up ? 4'd9 : 4'd0));
      ld_san[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd0 : load_val[4*i +: 4];
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q  <= '0;
      bcd_q  <= '0;
      step_q <= 1'b0;
      wrap_q <= 1'b0;
    end else if (load) begin
      pre_q  <= '0;
      bcd_q  <= ld_san;
      step_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      bcd_q  <= tick ? bcd_d : bcd_q;
      step_q <= tick;
      wrap_q <= tick && roll;
    end
  end
  assign bcd_out = bcd_q;
  assign step    = step_q;
  assign wrap    = wrap_q;
endmodule

// File: tb/tb_bcd_counter.sv
// tb_bcd_counter: directed vector table plus hand sequences for the BCD counter (DIV=4, DIGITS=4)
module tb_bcd_counter;
  typedef struct {
    logic        en, up, ld;
    logic [15:0] lv, bcd;
    logic        st, wr;
  } vec_t;
  logic        clk = 1'b0, rst = 1'b0, en = 1'b0, up = 1'b1, load = 1'b0;
  logic [15:0] load_val = '0, bcd_out;
  logic        step, wrap;
  int          checks = 0, failures = 0, nsteps = 0, nwraps = 0;
  vec_t        v[$];
  bcd_counter #(.DIGITS(4), .DIV(4)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
    .load_val(load_val), .bcd_out(bcd_out), .step(step), .wrap(wrap)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic add(input logic e, u, l, input logic [15:0] lv, b, input logic s, w);
    vec_t t;
    t.en = e; t.up = u; t.ld = l; t.lv = lv; t.bcd = b; t.st = s; t.wr = w;
    v.push_back(t);
  endtask
  task automatic addn(input int n, input logic e, u, l, input logic [15:0] lv, b, input logic s, w);
    for (int i = 0; i < n; i++) add(e, u, l, lv, b, s, w);
  endtask
  initial begin
    #2 rst = 1'b1;
    #1;
    chk("reset_bcd", 32'(bcd_out), 32'h0);
    chk("reset_step", 32'(step), 32'h0);
    chk("reset_wrap", 32'(wrap), 32'h0);
    @(negedge clk);
    rst = 1'b0; en = 1'b1; up = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("run%0d_bcd", k), 32'(bcd_out), (k / 4 == 10) ? 32'h0010 : 32'(k / 4));
      chk($sformatf("run%0d_step", k), 32'(step), 32'(k % 4 == 0));
      nsteps += int'(step);
      nwraps += int'(wrap);
    end
    chk("run_step_count", 32'(nsteps), 32'd10);
    chk("run_wrap_count", 32'(nwraps), 32'd0);
    add(1,1,1,'h0999,'h0999,0,0); addn(3,1,1,0,0,'h0999,0,0); add(1,1,0,0,'h1000,1,0);
    add(1,1,1,'h9999,'h9999,0,0); addn(3,1,1,0,0,'h9999,0,0); add(1,1,0,0,'h0000,1,1);
    add(1,0,1,'h0000,'h0000,0,0); addn(3,1,0,0,0,'h0000,0,0); add(1,0,0,0,'h9999,1,1);
    add(1,0,1,'h1000,'h1000,0,0); addn(3,1,0,0,0,'h1000,0,0); add(1,0,0,0,'h0999,1,0);
    addn(2,1,1,0,0,'h0999,0,0); addn(7,0,1,0,0,'h0999,0,0);
    add(1,1,0,0,'h0999,0,0); add(1,1,0,0,'h1000,1,0);
    addn(3,1,1,0,0,'h1000,0,0); add(1,1,1,'hA5F3,'h0503,0,0);
    addn(3,1,1,0,0,'h0503,0,0); add(1,1,0,0,'h0504,1,0);
    addn(2,1,1,0,0,'h0504,0,0); add(1,0,0,0,'h0504,0,0); add(1,0,0,0,'h0503,1,0);
    add(1,1,1,'h0426,'h0426,0,0); addn(3,1,1,0,0,'h0426,0,0); add(1,1,0,0,'h0427,1,0);
    for (int i = 0; i < v.size(); i++) begin
      en = v[i].en; up = v[i].up; load = v[i].ld; load_val = v[i].lv;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d_bcd", i), 32'(bcd_out), 32'(v[i].bcd));
      chk($sformatf("vec%0d_step", i), 32'(step), 32'(v[i].st));
      chk($sformatf("vec%0d_wrap", i), 32'(wrap), 32'(v[i].wr));
    end
    load = 1'b0; load_val = '0;
    #2 rst = 1'b1;
    #1;
    chk("async_bcd", 32'(bcd_out), 32'h0);
    chk("async_step", 32'(step), 32'h0);
    chk("async_wrap", 32'(wrap), 32'h0);
    @(negedge clk);
    rst = 1'b0; en = 1'b1; up = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("resume%0d_bcd", k), 32'(bcd_out), (k == 4) ? 32'h1 : 32'h0);
      chk($sformatf("resume%0d_step", k), 32'(step), 32'(k == 4));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
